// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice processes one nibble per clock, LSB first.
// Optional subtract mode is enabled by defining ADD_SEQ_SUB_EN (adds port sub).

module add_seq_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {4'b0, cin};
endmodule

module add_seq_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
`ifdef ADD_SEQ_SUB_EN
  input  logic         sub,
`endif
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         co
);
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          accept;
  logic [3:0]    a_nib, b_nib, sum;
  logic          cout;
  logic          sub_in, sub_q;

`ifdef ADD_SEQ_SUB_EN
  assign sub_in = sub;
  always_ff @(posedge clk) begin
    if (rst)         sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && start;

  // Subtraction is a + ~b + 1: invert each B nibble, carry seeded with 1.
  assign a_nib = a_q[4*cnt +: 4];
  assign b_nib = b_q[4*cnt +: 4] ^ {4{sub_q}};

  add_seq_slice u_slice (
    .x    (a_nib),
    .y    (b_nib),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cnt   <= '0;
      carry <= sub_in ? 1'b1 : ci;
      s     <= '0;
      co    <= 1'b0;
    end else if (state == RUN) begin
      s[4*cnt +: 4] <= sum;
      carry         <= cout;
      // Counter parks at LAST; the FSM leaves RUN on this same edge.
      if (cnt == LAST) co  <= cout;
      else             cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed-vector bench for add_seq_ctrl (NIBBLES=4), plus start-held, reset-abort and random sweeps.
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, ci;
  logic [15:0] a, b;
  logic        busy, done, co;
  logic [15:0] s;
`ifdef ADD_SEQ_SUB_EN
  logic        sub;
  bit          sub_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;

  add_seq_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ADD_SEQ_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation; operands are scrambled right after accept.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                       input logic [15:0] es, input logic eco);
    int n;
    int nbusy;
    @(negedge clk);
    a = ta; b = tb; ci = tci; start = 1'b1;
`ifdef ADD_SEQ_SUB_EN
    sub = sub_mode;
`endif
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
    sub = 1'($urandom);
`endif
    chk("s_clear_on_accept", {15'b0, co, s}, 32'h0);
    n = 1;
    nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    if (busy) nbusy++;
    chk("done_seen", {31'b0, done}, 32'h1);
    chk("latency", n, 5);
    chk("busy_cycles", nbusy, 5);
    chk("sum", {15'b0, co, s}, {15'b0, eco, es});
    @(negedge clk);
    chk("idle_after_done", {30'b0, busy, done}, 32'h0);
    chk("hold_result", {15'b0, co, s}, {15'b0, eco, es});
  endtask

  initial begin
    logic [16:0] g;
    logic [15:0] ra, rb, exp_s;
    logic        rci, exp_co;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
`ifdef ADD_SEQ_SUB_EN
    sub = 1'b0; sub_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_state", {13'b0, busy, done, co, s}, 32'h0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {30'b0, busy, done}, 32'h0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);

    // start held high: accepts only in IDLE, one result every 6 cycles
    exp_s = '0; exp_co = 1'b0;
    for (int p = 0; p <= 24; p++) begin
      if (p > 0) begin
        chk("held_done", {31'b0, done}, {31'b0, (p % 6) == 5});
        chk("held_busy", {31'b0, busy}, {31'b0, (p % 6) != 0});
        if ((p % 6) == 5) chk("held_sum", {15'b0, co, s}, {15'b0, exp_co, exp_s});
      end
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
      if ((p % 6) == 0) begin
        g = {1'b0, ra} + {1'b0, rb} + {16'b0, rci};
        exp_s = g[15:0]; exp_co = g[16];
      end
      a = ra; b = rb; ci = rci;
      start = (p != 24);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // reset two cycles after accept aborts with no done pulse
    a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", {13'b0, busy, done, co, s}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", {30'b0, busy, done}, 32'h0);
    end
    do_op(16'h4321, 16'h1234, 1'b1, 16'h5556, 1'b0);

`ifdef ADD_SEQ_SUB_EN
    sub_mode = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    sub_mode = 1'b0;
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
      g = {1'b0, ra} + {1'b0, rb} + {16'b0, rci};
      do_op(ra, rb, rci, g[15:0], g[16]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
